axi_slave_ram: RTL and testbench
================================

Name: axi_slave_ram

Overview:
- Single-clock AXI-style memory responder: the slave-end endpoint that terminates the S_* side of a slave async bridge.
- Accepts write and read address bursts, stores write data in an internal word array, and returns write responses and read data with ID echo.
- Write and read paths are independent state machines sharing one array: one write port, one read port.
- Used as an on-chip scratch/register RAM slave behind the bus interconnect.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the RAM window; must be 4-byte aligned.
- DEPTH_LOG2, 10, log2 of the word count (default 1024 x 32-bit words).

Ports:
- S_CLK  in  1  clock
- S_RSTN  in  1  asynchronous active-low reset
- S_WR_ADDR_ID/S_WR_ADDR/S_WR_ADDR_LEN/S_WR_ADDR_BURST  in  4/32/8/2  write address channel payload
- S_WR_ADDR_VALID in 1; S_WR_ADDR_READY out 1
- S_WR_DATA/S_WR_STRB/S_WR_DATA_LAST  in  32/4/1  write data payload
- S_WR_DATA_VALID in 1; S_WR_DATA_READY out 1
- S_WR_BACK_ID/S_WR_BACK_RESP  out  4/2  write response; S_WR_BACK_VALID out 1; S_WR_BACK_READY in 1
- S_RD_ADDR_ID/S_RD_ADDR/S_RD_ADDR_LEN/S_RD_ADDR_BURST  in  4/32/8/2  read address payload
- S_RD_ADDR_VALID in 1; S_RD_ADDR_READY out 1
- S_RD_BACK_ID/S_RD_DATA/S_RD_DATA_RESP/S_RD_DATA_LAST  out  4/32/2/1  read data payload
- S_RD_DATA_VALID out 1; S_RD_DATA_READY in 1

Behaviour:
- Interface clocking is fixed: one clock, S_CLK; S_RSTN is asynchronous, active-low.
- Reset: all VALID/READY outputs 0, all payload outputs 0, both FSMs go to IDLE.
  - Reset mid-burst aborts the burst with no response issued.
  - Array contents are not reset.
  - READY outputs rise on the first S_CLK edge after S_RSTN deasserts.
- Handshake: a transfer occurs when VALID and READY are both high on a rising edge.
  - Outputs hold payload stable while VALID is high and READY is low.
- Addressing:
  - Beat byte address A; word index = (A - ADDR_BASE) >> 2. Low two address bits are ignored.
  - Burst beats = LEN+1 (1..256).
  - BURST 2'b00 FIXED: same address every beat.
  - BURST 2'b01 INCR: +4 per beat; 32-bit wrap-around.
  - BURST 2'b10/2'b11: unsupported.
  - A beat is in range iff ADDR_BASE <= A < ADDR_BASE + 4*2^DEPTH_LOG2; range is evaluated per beat.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: WR_ADDR_READY=1 and WR_DATA_READY=0. On the AW handshake, latch ID/ADDR/LEN/BURST, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: WR_ADDR_READY=0 and WR_DATA_READY=1. Each accepted beat writes the array on that edge if the beat is in range and the burst is supported; otherwise the write is discarded and the error flag is set.
  - W_DATA LAST check: if WR_DATA_LAST != (counter==LEN), set the error flag; the data is still written.
  - W_DATA exit: after beat LEN, go to W_RESP regardless of the LAST flag; the beat counter is authoritative.
  - W_RESP: WR_BACK_VALID=1, BACK_ID = latched ID, RESP = SLVERR if the error flag is set, else OKAY. On the handshake, go to W_IDLE.
  - Minimum write latency: the response is valid one cycle after the last data beat is accepted.
  - Data presented before the address is not accepted, since WR_DATA_READY=0 in W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: RD_ADDR_READY=1. On the AR handshake, latch the command and go to R_DATA.
  - Read latency: the first beat's data is registered and RD_DATA_VALID=1 on the following cycle, i.e. one cycle after the AR handshake.
  - R_DATA: RD_ADDR_READY=0. On each handshake, advance and present the next beat the next cycle; back-to-back beats stream at one beat per cycle while READY is held high.
  - Read beat fields: RD_DATA_LAST=1 only on beat LEN. Out-of-range or unsupported beats return DATA=0 with RESP=SLVERR; other beats return OKAY.
  - After the LAST handshake, return to R_IDLE with VALID=0.
- Same-cycle collision: a write and a read to the same word on the same edge return the OLD data (read-before-write).
- No outstanding transaction queueing: one write and one read are in flight at most.

Optional Feature:
- Macro: SLAVE_RAM_STRB_EN.
- Defined: S_WR_STRB[i] enables byte lane i (bits 8i+7:8i). STRB=4'b0000 writes nothing but still counts as a beat, with OKAY response.
- Undefined: S_WR_STRB is ignored and every accepted in-range beat writes all 32 bits.

Test Plan:
- Reset then single write: AW ID=3, ADDR=ADDR_BASE+0x10, LEN=0, BURST=01; W DATA=0xDEADBEEF, LAST=1 -> BACK_ID=3, RESP=00 one cycle after the W beat; read of the same address returns 0xDEADBEEF, LAST=1, RESP=00, VALID one cycle after AR.
- INCR write, LEN=3, to ADDR_BASE: data 1,2,3,4 -> read LEN=3 returns 1,2,3,4 on consecutive cycles with READY held high; LAST only on beat 4. Toggle RD_DATA_READY low for 2 cycles mid-burst -> payload holds stable.
- FIXED write, LEN=2, data 0xA,0xB,0xC -> single-beat read returns 0xC.
- Out of range: write LEN=1 starting at the last word of the window -> RESP=10, first word written, second discarded. BURST=2'b10 read LEN=1 -> two beats DATA=0, RESP=10.
- LAST mismatch: LEN=1 with LAST=1 on beat 0 -> FSM still takes 2 beats, RESP=10. Assert S_RSTN low during W_DATA -> all VALID/READY 0 immediately, no response after reset.
- With SLAVE_RAM_STRB_EN: write 0xFFFFFFFF, then 0x12345678 with STRB=4'b0101 -> read returns 0xFF34FF78. Without the macro, the same sequence returns 0x12345678.

Source files
------------

// File: rtl/axi_slave_ram.sv
// AXI-style single-clock RAM slave with independent write/read FSMs sharing one word array.
// Optional macro SLAVE_RAM_STRB_EN enables per-byte write strobes (otherwise S_WR_STRB is ignored).
module axi_slave_ram #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        S_CLK,
    input  logic        S_RSTN,
    input  logic [3:0]  S_WR_ADDR_ID,
    input  logic [31:0] S_WR_ADDR,
    input  logic [7:0]  S_WR_ADDR_LEN,
    input  logic [1:0]  S_WR_ADDR_BURST,
    input  logic        S_WR_ADDR_VALID,
    output logic        S_WR_ADDR_READY,
    input  logic [31:0] S_WR_DATA,
    input  logic [3:0]  S_WR_STRB,
    input  logic        S_WR_DATA_LAST,
    input  logic        S_WR_DATA_VALID,
    output logic        S_WR_DATA_READY,
    output logic [3:0]  S_WR_BACK_ID,
    output logic [1:0]  S_WR_BACK_RESP,
    output logic        S_WR_BACK_VALID,
    input  logic        S_WR_BACK_READY,
    input  logic [3:0]  S_RD_ADDR_ID,
    input  logic [31:0] S_RD_ADDR,
    input  logic [7:0]  S_RD_ADDR_LEN,
    input  logic [1:0]  S_RD_ADDR_BURST,
    input  logic        S_RD_ADDR_VALID,
    output logic        S_RD_ADDR_READY,
    output logic [3:0]  S_RD_BACK_ID,
    output logic [31:0] S_RD_DATA,
    output logic [1:0]  S_RD_DATA_RESP,
    output logic        S_RD_DATA_LAST,
    output logic        S_RD_DATA_VALID,
    input  logic        S_RD_DATA_READY
);

    localparam int         DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (addr >= ADDR_BASE) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[DEPTH_LOG2+1:2];
    endfunction

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : (addr + 32'd4);
    endfunction

    logic [31:0] mem_r [DEPTH];

    w_state_t        w_state_r, w_next_s;
    r_state_t        r_state_r, r_next_s;
    logic [3:0]      wr_id_r;
    logic [31:0]     wr_addr_r;
    logic [7:0]      wr_len_r, wr_cnt_r;
    logic [1:0]      wr_burst_r;
    logic            wr_err_r, wr_err_s;
    logic            aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic            wr_last_beat_s, wr_beat_ok_s;
    logic            mem_we_s;
    logic [3:0]      mem_be_s;
    logic [DEPTH_LOG2-1:0] mem_idx_s;
    logic [31:0]     rd_addr_r, rd_beat_addr_s;
    logic [7:0]      rd_len_r, rd_cnt_r;
    logic [1:0]      rd_burst_r, rd_beat_burst_s;
    logic            rd_beat_ok_s, rd_beat_last_s, rd_last_beat_s;
    logic [31:0]     rd_word_s;

    assign aw_hs_s = S_WR_ADDR_VALID & S_WR_ADDR_READY;
    assign w_hs_s  = S_WR_DATA_VALID & S_WR_DATA_READY;
    assign b_hs_s  = S_WR_BACK_VALID & S_WR_BACK_READY;
    assign ar_hs_s = S_RD_ADDR_VALID & S_RD_ADDR_READY;
    assign r_hs_s  = S_RD_DATA_VALID & S_RD_DATA_READY;

`ifdef SLAVE_RAM_STRB_EN
    assign mem_be_s = S_WR_STRB;
`else
    logic strb_unused_s;
    assign strb_unused_s = ^S_WR_STRB;
    assign mem_be_s      = 4'hF;
`endif

    // Write beat qualification and running error flag
    always_comb begin
        wr_last_beat_s = (wr_cnt_r == wr_len_r);
        wr_beat_ok_s   = in_range(wr_addr_r) && burst_ok(wr_burst_r);
        mem_idx_s      = word_idx(wr_addr_r);
        mem_we_s       = w_hs_s & wr_beat_ok_s;
        wr_err_s       = wr_err_r;
        if (w_hs_s) begin
            wr_err_s = wr_err_r | ~wr_beat_ok_s | (S_WR_DATA_LAST != wr_last_beat_s);
        end else begin
            wr_err_s = wr_err_r;
        end
    end

    // Write FSM next state
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
            W_DATA:  if (w_hs_s && wr_last_beat_s) w_next_s = W_RESP; else w_next_s = W_DATA;
            W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Read beat selection: first beat comes straight from the AR payload
    always_comb begin
        rd_last_beat_s = (rd_cnt_r == rd_len_r);
        if (ar_hs_s) begin
            rd_beat_addr_s  = S_RD_ADDR;
            rd_beat_burst_s = S_RD_ADDR_BURST;
            rd_beat_last_s  = (S_RD_ADDR_LEN == 8'd0);
        end else begin
            rd_beat_addr_s  = next_addr(rd_addr_r, rd_burst_r);
            rd_beat_burst_s = rd_burst_r;
            rd_beat_last_s  = ((rd_cnt_r + 8'd1) == rd_len_r);
        end
        rd_beat_ok_s = in_range(rd_beat_addr_s) && burst_ok(rd_beat_burst_s);
        rd_word_s    = mem_r[word_idx(rd_beat_addr_s)];
    end

    // Read FSM next state
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
            R_DATA:  if (r_hs_s && rd_last_beat_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // State registers and handshake outputs, derived from the next state
    always_ff @(posedge S_CLK or negedge S_RSTN) begin
        if (!S_RSTN) begin
            w_state_r       <= W_IDLE;
            r_state_r       <= R_IDLE;
            S_WR_ADDR_READY <= 1'b0;
            S_WR_DATA_READY <= 1'b0;
            S_WR_BACK_VALID <= 1'b0;
            S_RD_ADDR_READY <= 1'b0;
            S_RD_DATA_VALID <= 1'b0;
        end else begin
            w_state_r       <= w_next_s;
            r_state_r       <= r_next_s;
            S_WR_ADDR_READY <= (w_next_s == W_IDLE);
            S_WR_DATA_READY <= (w_next_s == W_DATA);
            S_WR_BACK_VALID <= (w_next_s == W_RESP);
            S_RD_ADDR_READY <= (r_next_s == R_IDLE);
            S_RD_DATA_VALID <= (r_next_s == R_DATA);
        end
    end

    // Write command latch, beat tracking and response payload
    always_ff @(posedge S_CLK or negedge S_RSTN) begin
        if (!S_RSTN) begin
            wr_id_r        <= 4'd0;
            wr_addr_r      <= 32'd0;
            wr_len_r       <= 8'd0;
            wr_burst_r     <= 2'b00;
            wr_cnt_r       <= 8'd0;
            wr_err_r       <= 1'b0;
            S_WR_BACK_ID   <= 4'd0;
            S_WR_BACK_RESP <= 2'b00;
        end else if (aw_hs_s) begin
            wr_id_r    <= S_WR_ADDR_ID;
            wr_addr_r  <= S_WR_ADDR;
            wr_len_r   <= S_WR_ADDR_LEN;
            wr_burst_r <= S_WR_ADDR_BURST;
            wr_cnt_r   <= 8'd0;
            wr_err_r   <= 1'b0;
        end else if (w_hs_s) begin
            wr_addr_r <= next_addr(wr_addr_r, wr_burst_r);
            wr_cnt_r  <= wr_cnt_r + 8'd1;
            wr_err_r  <= wr_err_s;
            if (wr_last_beat_s) begin
                S_WR_BACK_ID   <= wr_id_r;
                S_WR_BACK_RESP <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Array write port; contents deliberately survive reset
    always_ff @(posedge S_CLK) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be_s[i]) begin
                    mem_r[mem_idx_s][8*i +: 8] <= S_WR_DATA[8*i +: 8];
                end
            end
        end
    end

    // Read command latch and registered beat payload (read-before-write on collision)
    always_ff @(posedge S_CLK or negedge S_RSTN) begin
        if (!S_RSTN) begin
            rd_addr_r      <= 32'd0;
            rd_len_r       <= 8'd0;
            rd_burst_r     <= 2'b00;
            rd_cnt_r       <= 8'd0;
            S_RD_BACK_ID   <= 4'd0;
            S_RD_DATA      <= 32'd0;
            S_RD_DATA_RESP <= 2'b00;
            S_RD_DATA_LAST <= 1'b0;
        end else if (ar_hs_s || (r_hs_s && !rd_last_beat_s)) begin
            if (ar_hs_s) begin
                rd_len_r     <= S_RD_ADDR_LEN;
                rd_burst_r   <= S_RD_ADDR_BURST;
                rd_cnt_r     <= 8'd0;
                S_RD_BACK_ID <= S_RD_ADDR_ID;
            end else begin
                rd_cnt_r <= rd_cnt_r + 8'd1;
            end
            rd_addr_r      <= rd_beat_addr_s;
            S_RD_DATA      <= rd_beat_ok_s ? rd_word_s : 32'd0;
            S_RD_DATA_RESP <= rd_beat_ok_s ? RESP_OKAY : RESP_SLVERR;
            S_RD_DATA_LAST <= rd_beat_last_s;
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram (small 16-word window at 0x1000).
module tb_axi_slave_ram;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DLOG = 4;

    logic        S_CLK = 1'b0;
    logic        S_RSTN;
    logic [3:0]  S_WR_ADDR_ID;
    logic [31:0] S_WR_ADDR;
    logic [7:0]  S_WR_ADDR_LEN;
    logic [1:0]  S_WR_ADDR_BURST;
    logic        S_WR_ADDR_VALID, S_WR_ADDR_READY;
    logic [31:0] S_WR_DATA;
    logic [3:0]  S_WR_STRB;
    logic        S_WR_DATA_LAST, S_WR_DATA_VALID, S_WR_DATA_READY;
    logic [3:0]  S_WR_BACK_ID;
    logic [1:0]  S_WR_BACK_RESP;
    logic        S_WR_BACK_VALID, S_WR_BACK_READY;
    logic [3:0]  S_RD_ADDR_ID;
    logic [31:0] S_RD_ADDR;
    logic [7:0]  S_RD_ADDR_LEN;
    logic [1:0]  S_RD_ADDR_BURST;
    logic        S_RD_ADDR_VALID, S_RD_ADDR_READY;
    logic [3:0]  S_RD_BACK_ID;
    logic [31:0] S_RD_DATA;
    logic [1:0]  S_RD_DATA_RESP;
    logic        S_RD_DATA_LAST, S_RD_DATA_VALID, S_RD_DATA_READY;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [31:0] rd_data_q  [8];
    logic [1:0]  rd_resp_q  [8];
    logic        rd_last_q  [8];
    logic        rd_valid_q [8];

    always #5 S_CLK = ~S_CLK;

    axi_slave_ram #(.ADDR_BASE(BASE), .DEPTH_LOG2(DLOG)) dut (
        .S_CLK(S_CLK), .S_RSTN(S_RSTN),
        .S_WR_ADDR_ID(S_WR_ADDR_ID), .S_WR_ADDR(S_WR_ADDR), .S_WR_ADDR_LEN(S_WR_ADDR_LEN),
        .S_WR_ADDR_BURST(S_WR_ADDR_BURST), .S_WR_ADDR_VALID(S_WR_ADDR_VALID), .S_WR_ADDR_READY(S_WR_ADDR_READY),
        .S_WR_DATA(S_WR_DATA), .S_WR_STRB(S_WR_STRB), .S_WR_DATA_LAST(S_WR_DATA_LAST),
        .S_WR_DATA_VALID(S_WR_DATA_VALID), .S_WR_DATA_READY(S_WR_DATA_READY),
        .S_WR_BACK_ID(S_WR_BACK_ID), .S_WR_BACK_RESP(S_WR_BACK_RESP),
        .S_WR_BACK_VALID(S_WR_BACK_VALID), .S_WR_BACK_READY(S_WR_BACK_READY),
        .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR), .S_RD_ADDR_LEN(S_RD_ADDR_LEN),
        .S_RD_ADDR_BURST(S_RD_ADDR_BURST), .S_RD_ADDR_VALID(S_RD_ADDR_VALID), .S_RD_ADDR_READY(S_RD_ADDR_READY),
        .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_DATA(S_RD_DATA), .S_RD_DATA_RESP(S_RD_DATA_RESP),
        .S_RD_DATA_LAST(S_RD_DATA_LAST), .S_RD_DATA_VALID(S_RD_DATA_VALID), .S_RD_DATA_READY(S_RD_DATA_READY)
    );

    // Drivers: each leaves the bench at 1ns after the handshake edge
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        S_WR_ADDR_ID = id; S_WR_ADDR = addr; S_WR_ADDR_LEN = len; S_WR_ADDR_BURST = burst;
        S_WR_ADDR_VALID = 1'b1;
        while (S_WR_ADDR_READY !== 1'b1 && n < 50) begin @(posedge S_CLK); #1; n++; end
        if (n >= 50) begin test_cnt++; fail_cnt++; $display("FAIL aw_timeout: ready=%b required 1", S_WR_ADDR_READY); end
        @(posedge S_CLK); #1;
        S_WR_ADDR_VALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        S_WR_DATA = data; S_WR_STRB = strb; S_WR_DATA_LAST = last; S_WR_DATA_VALID = 1'b1;
        while (S_WR_DATA_READY !== 1'b1 && n < 50) begin @(posedge S_CLK); #1; n++; end
        if (n >= 50) begin test_cnt++; fail_cnt++; $display("FAIL w_timeout: ready=%b required 1", S_WR_DATA_READY); end
        @(posedge S_CLK); #1;
        S_WR_DATA_VALID = 1'b0; S_WR_DATA_LAST = 1'b0;
    endtask

    task automatic do_b();
        int n = 0;
        S_WR_BACK_READY = 1'b1;
        while (S_WR_BACK_VALID !== 1'b1 && n < 50) begin @(posedge S_CLK); #1; n++; end
        if (n >= 50) begin test_cnt++; fail_cnt++; $display("FAIL b_timeout: valid=%b required 1", S_WR_BACK_VALID); end
        @(posedge S_CLK); #1;
        S_WR_BACK_READY = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        S_RD_ADDR_ID = id; S_RD_ADDR = addr; S_RD_ADDR_LEN = len; S_RD_ADDR_BURST = burst;
        S_RD_ADDR_VALID = 1'b1;
        while (S_RD_ADDR_READY !== 1'b1 && n < 50) begin @(posedge S_CLK); #1; n++; end
        if (n >= 50) begin test_cnt++; fail_cnt++; $display("FAIL ar_timeout: ready=%b required 1", S_RD_ADDR_READY); end
        @(posedge S_CLK); #1;
        S_RD_ADDR_VALID = 1'b0;
    endtask

    // Captures n beats with READY held high, one sample per cycle
    task automatic rd_beats(input int n);
        S_RD_DATA_READY = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_valid_q[i] = S_RD_DATA_VALID; rd_data_q[i] = S_RD_DATA;
            rd_resp_q[i]  = S_RD_DATA_RESP;  rd_last_q[i] = S_RD_DATA_LAST;
            @(posedge S_CLK); #1;
        end
        S_RD_DATA_READY = 1'b0;
    endtask

    task automatic test_reset();
        S_RSTN = 1'b0;
        S_WR_ADDR_VALID = 1'b0; S_WR_DATA_VALID = 1'b0; S_WR_BACK_READY = 1'b0;
        S_RD_ADDR_VALID = 1'b0; S_RD_DATA_READY = 1'b0;
        S_WR_ADDR_ID = 4'd0; S_WR_ADDR = 32'd0; S_WR_ADDR_LEN = 8'd0; S_WR_ADDR_BURST = 2'b00;
        S_WR_DATA = 32'd0; S_WR_STRB = 4'hF; S_WR_DATA_LAST = 1'b0;
        S_RD_ADDR_ID = 4'd0; S_RD_ADDR = 32'd0; S_RD_ADDR_LEN = 8'd0; S_RD_ADDR_BURST = 2'b00;
        repeat (3) @(posedge S_CLK);
        #1;
        test_cnt++;
        if ({S_WR_ADDR_READY, S_WR_DATA_READY, S_WR_BACK_VALID, S_RD_ADDR_READY, S_RD_DATA_VALID} !== 5'b0) begin
            fail_cnt++; $display("FAIL reset_hs: got %b expected 00000",
                {S_WR_ADDR_READY, S_WR_DATA_READY, S_WR_BACK_VALID, S_RD_ADDR_READY, S_RD_DATA_VALID});
        end
        test_cnt++;
        if ({S_WR_BACK_ID, S_WR_BACK_RESP, S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST} !== 45'd0) begin
            fail_cnt++; $display("FAIL reset_payload: got %h expected 0",
                {S_WR_BACK_ID, S_WR_BACK_RESP, S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST});
        end
        @(negedge S_CLK); S_RSTN = 1'b1; #1;
        test_cnt++;
        if (S_WR_ADDR_READY !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready_early: got %b expected 0", S_WR_ADDR_READY); end
        @(posedge S_CLK); #1;
        test_cnt++;
        if ({S_WR_ADDR_READY, S_WR_DATA_READY, S_RD_ADDR_READY} !== 3'b101) begin
            fail_cnt++; $display("FAIL reset_ready_rise: got %b expected 101", {S_WR_ADDR_READY, S_WR_DATA_READY, S_RD_ADDR_READY});
        end
    endtask

    task automatic test_single();
        do_aw(4'd3, BASE + 32'h10, 8'd0, 2'b01);
        test_cnt++;
        if ({S_WR_ADDR_READY, S_WR_DATA_READY} !== 2'b01) begin
            fail_cnt++; $display("FAIL single_w_ready: got %b expected 01", {S_WR_ADDR_READY, S_WR_DATA_READY});
        end
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_BACK_ID, S_WR_BACK_RESP} !== {1'b1, 4'd3, 2'b00}) begin
            fail_cnt++; $display("FAIL single_bresp: got v=%b id=%h r=%b expected v=1 id=3 r=00", S_WR_BACK_VALID, S_WR_BACK_ID, S_WR_BACK_RESP);
        end
        do_b();
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_ADDR_READY} !== 2'b01) begin
            fail_cnt++; $display("FAIL single_b_done: got %b expected 01", {S_WR_BACK_VALID, S_WR_ADDR_READY});
        end
        do_ar(4'd5, BASE + 32'h10, 8'd0, 2'b01);
        test_cnt++;
        if ({S_RD_DATA_VALID, S_RD_ADDR_READY, S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST} !== {1'b1, 1'b0, 4'd5, 32'hDEAD_BEEF, 2'b00, 1'b1}) begin
            fail_cnt++; $display("FAIL single_read: got v=%b id=%h d=%h r=%b l=%b expected v=1 id=5 d=deadbeef r=00 l=1",
                S_RD_DATA_VALID, S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST);
        end
        rd_beats(1);
        test_cnt++;
        if ({S_RD_DATA_VALID, S_RD_ADDR_READY} !== 2'b01) begin
            fail_cnt++; $display("FAIL single_read_done: got %b expected 01", {S_RD_DATA_VALID, S_RD_ADDR_READY});
        end
    endtask

    task automatic test_incr();
        do_aw(4'd1, BASE, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(32'(i + 1), 4'hF, (i == 3));
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_BACK_RESP} !== 3'b100) begin
            fail_cnt++; $display("FAIL incr_bresp: got %b expected 100", {S_WR_BACK_VALID, S_WR_BACK_RESP});
        end
        do_b();
        do_ar(4'd2, BASE, 8'd3, 2'b01);
        rd_beats(2);
        for (int i = 0; i < 2; i++) begin
            test_cnt++;
            if ({rd_valid_q[i], rd_data_q[i], rd_resp_q[i], rd_last_q[i]} !== {1'b1, 32'(i + 1), 2'b00, 1'b0}) begin
                fail_cnt++; $display("FAIL incr_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=0", i, rd_valid_q[i], rd_data_q[i], rd_last_q[i], i + 1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge S_CLK); #1;
            test_cnt++;
            if ({S_RD_DATA_VALID, S_RD_DATA, S_RD_DATA_LAST, S_RD_BACK_ID} !== {1'b1, 32'd3, 1'b0, 4'd2}) begin
                fail_cnt++; $display("FAIL incr_hold%0d: got v=%b d=%h l=%b id=%h expected v=1 d=3 l=0 id=2", k, S_RD_DATA_VALID, S_RD_DATA, S_RD_DATA_LAST, S_RD_BACK_ID);
            end
        end
        rd_beats(2);
        for (int i = 0; i < 2; i++) begin
            test_cnt++;
            if ({rd_valid_q[i], rd_data_q[i], rd_resp_q[i], rd_last_q[i]} !== {1'b1, 32'(i + 3), 2'b00, (i == 1)}) begin
                fail_cnt++; $display("FAIL incr_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i + 2, rd_valid_q[i], rd_data_q[i], rd_last_q[i], i + 3, (i == 1));
            end
        end
        test_cnt++;
        if (S_RD_DATA_VALID !== 1'b0) begin fail_cnt++; $display("FAIL incr_end_valid: got %b expected 0", S_RD_DATA_VALID); end
    endtask

    task automatic test_fixed();
        do_aw(4'd4, BASE + 32'h20, 8'd2, 2'b00);
        do_w(32'hA, 4'hF, 1'b0);
        do_w(32'hB, 4'hF, 1'b0);
        do_w(32'hC, 4'hF, 1'b1);
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_BACK_RESP} !== 3'b100) begin
            fail_cnt++; $display("FAIL fixed_bresp: got %b expected 100", {S_WR_BACK_VALID, S_WR_BACK_RESP});
        end
        do_b();
        do_ar(4'd4, BASE + 32'h20, 8'd0, 2'b01);
        rd_beats(1);
        test_cnt++;
        if ({rd_data_q[0], rd_resp_q[0], rd_last_q[0]} !== {32'hC, 2'b00, 1'b1}) begin
            fail_cnt++; $display("FAIL fixed_read: got d=%h r=%b l=%b expected d=c r=00 l=1", rd_data_q[0], rd_resp_q[0], rd_last_q[0]);
        end
    endtask

    task automatic test_out_of_range();
        do_aw(4'd6, BASE + 32'h3C, 8'd1, 2'b01);
        do_w(32'h1111_1111, 4'hF, 1'b0);
        do_w(32'h2222_2222, 4'hF, 1'b1);
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_BACK_RESP} !== 3'b110) begin
            fail_cnt++; $display("FAIL oor_bresp: got %b expected 110", {S_WR_BACK_VALID, S_WR_BACK_RESP});
        end
        do_b();
        do_ar(4'd6, BASE + 32'h3C, 8'd1, 2'b01);
        rd_beats(2);
        test_cnt++;
        if ({rd_data_q[0], rd_resp_q[0], rd_data_q[1], rd_resp_q[1], rd_last_q[1]} !== {32'h1111_1111, 2'b00, 32'd0, 2'b10, 1'b1}) begin
            fail_cnt++; $display("FAIL oor_read: got %h/%b %h/%b expected 11111111/00 00000000/10", rd_data_q[0], rd_resp_q[0], rd_data_q[1], rd_resp_q[1]);
        end
        do_aw(4'd6, BASE, 8'd0, 2'b11);
        do_w(32'h99, 4'hF, 1'b1);
        test_cnt++;
        if (S_WR_BACK_RESP !== 2'b10) begin fail_cnt++; $display("FAIL oor_burst_wresp: got %b expected 10", S_WR_BACK_RESP); end
        do_b();
        do_ar(4'd0, BASE, 8'd0, 2'b01);
        rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== 32'd1) begin fail_cnt++; $display("FAIL oor_no_alias: got %h expected 1", rd_data_q[0]); end
        do_ar(4'd8, BASE, 8'd1, 2'b10);
        rd_beats(2);
        test_cnt++;
        if ({rd_data_q[0], rd_resp_q[0], rd_data_q[1], rd_resp_q[1], rd_valid_q[1]} !== {32'd0, 2'b10, 32'd0, 2'b10, 1'b1}) begin
            fail_cnt++; $display("FAIL oor_burst_read: got %h/%b %h/%b expected 0/10 0/10", rd_data_q[0], rd_resp_q[0], rd_data_q[1], rd_resp_q[1]);
        end
        do_ar(4'd8, BASE - 32'd4, 8'd0, 2'b01);
        rd_beats(1);
        test_cnt++;
        if ({rd_data_q[0], rd_resp_q[0]} !== {32'd0, 2'b10}) begin
            fail_cnt++; $display("FAIL oor_below_base: got %h/%b expected 0/10", rd_data_q[0], rd_resp_q[0]);
        end
    endtask

    task automatic test_last_mismatch();
        do_aw(4'd9, BASE + 32'h30, 8'd1, 2'b01);
        do_w(32'h55, 4'hF, 1'b1);
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_DATA_READY} !== 2'b01) begin
            fail_cnt++; $display("FAIL lastmm_still_data: got %b expected 01", {S_WR_BACK_VALID, S_WR_DATA_READY});
        end
        do_w(32'h66, 4'hF, 1'b0);
        test_cnt++;
        if ({S_WR_BACK_VALID, S_WR_BACK_ID, S_WR_BACK_RESP} !== {1'b1, 4'd9, 2'b10}) begin
            fail_cnt++; $display("FAIL lastmm_bresp: got v=%b id=%h r=%b expected v=1 id=9 r=10", S_WR_BACK_VALID, S_WR_BACK_ID, S_WR_BACK_RESP);
        end
        do_b();
        do_ar(4'd9, BASE + 32'h30, 8'd1, 2'b01);
        rd_beats(2);
        test_cnt++;
        if ({rd_data_q[0], rd_data_q[1]} !== {32'h55, 32'h66}) begin
            fail_cnt++; $display("FAIL lastmm_data: got %h %h expected 55 66", rd_data_q[0], rd_data_q[1]);
        end
    endtask

    task automatic test_collision();
        do_aw(4'd2, BASE + 32'h8, 8'd0, 2'b01);
        S_WR_DATA = 32'hC0C0_C0C0; S_WR_STRB = 4'hF; S_WR_DATA_LAST = 1'b1; S_WR_DATA_VALID = 1'b1;
        S_RD_ADDR_ID = 4'd2; S_RD_ADDR = BASE + 32'h8; S_RD_ADDR_LEN = 8'd0; S_RD_ADDR_BURST = 2'b01; S_RD_ADDR_VALID = 1'b1;
        test_cnt++;
        if ({S_WR_DATA_READY, S_RD_ADDR_READY} !== 2'b11) begin
            fail_cnt++; $display("FAIL coll_ready: got %b expected 11", {S_WR_DATA_READY, S_RD_ADDR_READY});
        end
        @(posedge S_CLK); #1;
        S_WR_DATA_VALID = 1'b0; S_WR_DATA_LAST = 1'b0; S_RD_ADDR_VALID = 1'b0;
        test_cnt++;
        if ({S_RD_DATA_VALID, S_RD_DATA} !== {1'b1, 32'd3}) begin
            fail_cnt++; $display("FAIL coll_old_data: got v=%b d=%h expected v=1 d=3", S_RD_DATA_VALID, S_RD_DATA);
        end
        rd_beats(1);
        do_b();
        do_ar(4'd2, BASE + 32'h8, 8'd0, 2'b01);
        rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== 32'hC0C0_C0C0) begin fail_cnt++; $display("FAIL coll_new_data: got %h expected c0c0c0c0", rd_data_q[0]); end
    endtask

    task automatic test_strb();
        logic [31:0] exp_a, exp_b;
`ifdef SLAVE_RAM_STRB_EN
        exp_a = 32'hFF34_FF78; exp_b = 32'hFF34_FF78;
`else
        exp_a = 32'h1234_5678; exp_b = 32'hAAAA_AAAA;
`endif
        do_aw(4'd1, BASE + 32'h28, 8'd0, 2'b01); do_w(32'hFFFF_FFFF, 4'hF, 1'b1); do_b();
        do_aw(4'd1, BASE + 32'h28, 8'd0, 2'b01); do_w(32'h1234_5678, 4'b0101, 1'b1); do_b();
        do_ar(4'd1, BASE + 32'h28, 8'd0, 2'b01); rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== exp_a) begin fail_cnt++; $display("FAIL strb_0101: got %h expected %h", rd_data_q[0], exp_a); end
        do_aw(4'd1, BASE + 32'h28, 8'd0, 2'b01); do_w(32'hAAAA_AAAA, 4'b0000, 1'b1);
        test_cnt++;
        if (S_WR_BACK_RESP !== 2'b00) begin fail_cnt++; $display("FAIL strb_zero_resp: got %b expected 00", S_WR_BACK_RESP); end
        do_b();
        do_ar(4'd1, BASE + 32'h28, 8'd0, 2'b01); rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== exp_b) begin fail_cnt++; $display("FAIL strb_0000: got %h expected %h", rd_data_q[0], exp_b); end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        do_aw(4'd7, BASE + 32'h4, 8'd3, 2'b01);
        do_w(32'h77, 4'hF, 1'b0);
        #2; S_RSTN = 1'b0; #1;
        test_cnt++;
        if ({S_WR_ADDR_READY, S_WR_DATA_READY, S_WR_BACK_VALID, S_RD_ADDR_READY, S_RD_DATA_VALID} !== 5'b0) begin
            fail_cnt++; $display("FAIL rstmid_async: got %b expected 00000",
                {S_WR_ADDR_READY, S_WR_DATA_READY, S_WR_BACK_VALID, S_RD_ADDR_READY, S_RD_DATA_VALID});
        end
        repeat (2) @(posedge S_CLK);
        @(negedge S_CLK); S_RSTN = 1'b1;
        S_WR_BACK_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge S_CLK); #1;
            if (S_WR_BACK_VALID === 1'b1) seen++;
        end
        test_cnt++;
        if (seen != 0) begin fail_cnt++; $display("FAIL rstmid_no_resp: got %0d valid cycles expected 0", seen); end
        test_cnt++;
        if ({S_WR_ADDR_READY, S_WR_DATA_READY} !== 2'b10) begin
            fail_cnt++; $display("FAIL rstmid_idle: got %b expected 10", {S_WR_ADDR_READY, S_WR_DATA_READY});
        end
        do_ar(4'd3, BASE + 32'h4, 8'd0, 2'b01); rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== 32'h77) begin fail_cnt++; $display("FAIL rstmid_kept_beat: got %h expected 77", rd_data_q[0]); end
        do_ar(4'd3, BASE + 32'h10, 8'd0, 2'b01); rd_beats(1);
        test_cnt++;
        if (rd_data_q[0] !== 32'hDEAD_BEEF) begin fail_cnt++; $display("FAIL rstmid_array_kept: got %h expected deadbeef", rd_data_q[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_fixed();
        test_out_of_range();
        test_last_mismatch();
        test_collision();
        test_strb();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
